matrix_serializer: RTL and testbench
====================================

// Module: matrix_serializer
// PURPOSE
//  Output stage for the matrix precision datapath, directly downstream of the matrix subtract stage.
//  - Captures a whole R x C result matrix on its one-cycle valid strobe.
//  - Streams the matrix out one element per handshake, in row-major order, with valid/ready backpressure.
//  - Lets a single narrow consumer (FIFO, AXI-stream bridge, UART dumper) take matrix results at its own pace.
// PARAMETERS
//  BITS       16      element width (raw float bit pattern, never interpreted)
//  PRECISION  "HALF"  carried for datapath consistency; no arithmetic uses it
//  R          2       matrix rows, >= 1
//  C          2       matrix columns, >= 1
// PORTS
//  clk        in   1                 clock, all logic on rising edge
//  rst_n      in   1                 asynchronous active-low reset
//  in_valid   in   1                 one-cycle strobe: m_in holds a new matrix
//  m_in       in   [BITS-1:0][R][C]  matrix from the subtract stage (unpacked [R][C])
//  in_ready   out  1                 capture possible this cycle (informational; upstream cannot stall)
//  out_valid  out  1                 out_data holds a valid element
//  out_ready  in   1                 consumer accepts the element
//  out_data   out  BITS              current element m[out_row][out_col]
//  out_row    out  $clog2(R)         row index of out_data (1 bit minimum)
//  out_col    out  $clog2(C)         column index of out_data (1 bit minimum)
//  out_last   out  1                 out_data is element [R-1][C-1]
//  overflow   out  1                 sticky: a matrix was dropped
// BEHAVIOUR
//  Reset values
//  - state=IDLE; out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, overflow=0; in_ready=1.
//  - Reset asserted mid-drain discards the held matrix and any pending matrix immediately.
//  States
//  - IDLE: nothing held. in_valid -> capture m_in into the active buffer -> DRAIN.
//  - DRAIN: out_valid=1. The first element [0][0] is presented the cycle after capture (latency 1).
//  Handshake
//  - A transfer is out_valid && out_ready on a rising edge.
//  - out_data/out_row/out_col/out_last hold stable while out_valid && !out_ready.
//  - After each transfer col++. When col wraps at C-1: col=0, row++.
//  - Transfer with out_last=1 ends the matrix. With nothing pending -> IDLE, out_valid=0 next cycle.
//  Capture rules
//  - in_ready = (state==IDLE) || (out_last && out_ready).
//  - in_valid in the same cycle as the final transfer is accepted: next cycle presents [0][0] of the new matrix, no bubble.
//  - in_valid while !in_ready: matrix dropped, overflow<=1. overflow clears only on reset.
//  - The held matrix is never modified by in_valid.
//  Degenerate sizes
//  - R=1 or C=1: the corresponding index stays 0.
//  - R=C=1: out_last=1 on every element.
// CONFIGURATION
//  MATRIX_SERIALIZER_PEND_EN
//  - Defined: adds one pending-matrix buffer.
//    - in_ready = !pend_valid || (out_last && out_ready).
//    - in_valid during DRAIN with pending empty -> capture into pending.
//    - On the final transfer, pending is promoted to active: out_valid stays 1 and [0][0] of the pending matrix is presented next cycle.
//    - Final transfer, pending full, and in_valid in the same cycle: pending is promoted and the new matrix enters pending.
//    - Final transfer, pending empty, and in_valid in the same cycle: the new matrix goes straight to active.
//  - Undefined: no pending buffer; in_ready is as defined under BEHAVIOUR; any matrix arriving mid-drain sets overflow.
// STRUCTURE
//  - Package precision_pkg, shared with the other matrix stages:
//    - idx_w(n) function: $clog2 with minimum 1.
//    - serializer state enum {IDLE, DRAIN}.
//  - Sub-module matrix_hold_buffer: R x C register bank with load enable and a (row,col) read mux.
//    - Instantiated once, or twice when MATRIX_SERIALIZER_PEND_EN is defined.
//  - Top-level logic: FSM, index counters, overflow flag.
// TESTING (BITS=16, R=2, C=2; m[r][c] = 16'h0100*(r+1) + c)
//  1. Single matrix, out_ready=1:
//     - in_valid at cycle 0 -> out_data 0100,0101,0200,0201 on cycles 1-4, out_last on cycle 4 only.
//     - out_valid=0 on cycle 5.
//  2. Backpressure: out_ready=0 for 3 cycles after [0][1] is presented
//     -> 0101 / row 0 / col 1 held stable; stream then resumes in order.
//  3. Drop (macro undefined): second in_valid while [0][0] is held -> overflow=1, first matrix drains unchanged.
//  4. Back-to-back: second in_valid in the cycle of the final transfer
//     -> next cycle out_valid=1 and out_data = [0][0] of the new matrix.
//  5. PEND_EN: three matrices strobed at cycles 0, 1, 2, out_ready=1
//     -> first two stream gaplessly over 8 cycles; the third sets overflow.
//  6. rst_n low for 1 cycle during the [1][0] transfer
//     -> all outputs at reset values, overflow=0; the next in_valid restarts at [0][0].

Source files
------------

// File: rtl/precision_pkg.sv
// Shared types and helpers for the matrix precision datapath stages.
package precision_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } ser_state_e;

    // Index width for a dimension of size n; never narrower than one bit.
    function automatic int idx_w(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_hold_buffer.sv
// R x C register bank: whole-matrix load on load, single-element read by (row, col).
module matrix_hold_buffer
    import precision_pkg::*;
#(
    parameter int BITS = 16,
    parameter int R    = 2,
    parameter int C    = 2,
    localparam int RW  = idx_w(R),
    localparam int CW  = idx_w(C)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [BITS-1:0] d [R][C],
    input  logic [RW-1:0]   rd_row,
    input  logic [CW-1:0]   rd_col,
    output logic [BITS-1:0] rd_data
);

    logic [BITS-1:0] mem_q [R][C];
    logic [BITS-1:0] mem_d [R][C];

    always_comb begin
        mem_d = mem_q;
        if (load) mem_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    // Compare-based mux keeps out-of-range indices (non power-of-two R/C) at zero.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (rd_row == RW'(r) && rd_col == CW'(c)) rd_data = mem_q[r][c];
            end
        end
    end

endmodule

// File: rtl/matrix_serializer.sv
// Captures an R x C matrix on a valid strobe and streams it out row-major over valid/ready.
// Define MATRIX_SERIALIZER_PEND_EN to add a second (pending) matrix buffer.
//
// state | meaning
// IDLE  | nothing held, waiting for in_valid
// DRAIN | active matrix presented element by element on out_*
module matrix_serializer
    import precision_pkg::*;
#(
    parameter int BITS      = 16,
    parameter     PRECISION = "HALF",
    parameter int R         = 2,
    parameter int C         = 2,
    localparam int RW       = idx_w(R),
    localparam int CW       = idx_w(C)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [BITS-1:0] m_in [R][C],
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic [RW-1:0]   out_row,
    output logic [CW-1:0]   out_col,
    output logic            out_last,
    output logic            overflow
);

    if (R < 1 || C < 1 || BITS < 1 || PRECISION == 0) begin : g_bad_params
        $error("matrix_serializer: invalid parameters");
    end

    ser_state_e      state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            overflow_q, overflow_d;
    logic            last_elem, xfer, final_xfer, more;
    logic [BITS-1:0] rd_act;

`ifdef MATRIX_SERIALIZER_PEND_EN
    logic            pend_valid_q, pend_valid_d;
    logic            act_sel_q, act_sel_d;
    logic            ld_cur, ld_oth;
    logic            load0, load1;
    logic [BITS-1:0] rd0, rd1;

    // Ping-pong pair: act_sel_q names the buffer being drained, the other one is pending.
    always_comb begin
        pend_valid_d = pend_valid_q;
        act_sel_d    = act_sel_q;
        ld_cur       = 1'b0;
        ld_oth       = 1'b0;
        if (state_q == IDLE) begin
            ld_cur = in_valid;
        end else if (final_xfer) begin
            ld_cur = in_valid;
            if (pend_valid_q) begin
                act_sel_d    = !act_sel_q;
                pend_valid_d = in_valid;
            end
        end else if (in_valid && !pend_valid_q) begin
            ld_oth       = 1'b1;
            pend_valid_d = 1'b1;
        end
        load0 = (ld_cur && !act_sel_q) || (ld_oth && act_sel_q);
        load1 = (ld_cur && act_sel_q) || (ld_oth && !act_sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            act_sel_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            act_sel_q    <= act_sel_d;
        end
    end

    matrix_hold_buffer #(.BITS(BITS), .R(R), .C(C)) u_buf0 (
        .clk(clk), .rst_n(rst_n), .load(load0), .d(m_in),
        .rd_row(row_q), .rd_col(col_q), .rd_data(rd0)
    );

    matrix_hold_buffer #(.BITS(BITS), .R(R), .C(C)) u_buf1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .d(m_in),
        .rd_row(row_q), .rd_col(col_q), .rd_data(rd1)
    );

    assign rd_act   = act_sel_q ? rd1 : rd0;
    assign in_ready = !pend_valid_q || final_xfer;
    assign more     = in_valid || pend_valid_q;
`else
    logic load_act;

    assign load_act = in_valid && in_ready;

    matrix_hold_buffer #(.BITS(BITS), .R(R), .C(C)) u_buf0 (
        .clk(clk), .rst_n(rst_n), .load(load_act), .d(m_in),
        .rd_row(row_q), .rd_col(col_q), .rd_data(rd_act)
    );

    assign in_ready = (state_q == IDLE) || final_xfer;
    assign more     = in_valid;
`endif

    always_comb begin
        last_elem  = (row_q == RW'(R - 1)) && (col_q == CW'(C - 1));
        out_valid  = (state_q == DRAIN);
        out_last   = out_valid && last_elem;
        xfer       = out_valid && out_ready;
        final_xfer = xfer && last_elem;
        out_data   = out_valid ? rd_act : '0;
        out_row    = row_q;
        out_col    = col_q;
        overflow   = overflow_q;
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        overflow_d = overflow_q | (in_valid && !in_ready);
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = DRAIN;
            end
            DRAIN: begin
                if (xfer) begin
                    if (last_elem) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = more ? DRAIN : IDLE;
                    end else if (col_q == CW'(C - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_matrix_serializer.sv
// Scoreboard bench for matrix_serializer (2x2, 16-bit); pending-buffer scenario under MATRIX_SERIALIZER_PEND_EN.
module tb_matrix_serializer;

    localparam int BITS = 16;
    localparam int R    = 2;
    localparam int C    = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] m_in [R][C];
    logic            in_ready, out_valid, out_last, overflow;
    logic [BITS-1:0] out_data;
    logic            out_row, out_col;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [BITS-1:0] data;
        logic            row;
        logic            col;
        logic            last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    matrix_serializer #(.BITS(BITS), .PRECISION("HALF"), .R(R), .C(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .m_in(m_in), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .overflow(overflow)
    );

    function automatic logic [BITS-1:0] elem(input int k, input int r, input int c);
        return 16'(32'h1000 * k + 32'h0100 * (r + 1) + c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a matrix strobe; accepted matrices are queued row-major on the scoreboard.
    task automatic present(input int k, input bit accept);
        exp_t e;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                m_in[r][c] = elem(k, r, c);
                if (accept) begin
                    e.data = elem(k, r, c);
                    e.row  = 1'(r);
                    e.col  = 1'(c);
                    e.last = (r == R - 1) && (c == C - 1);
                    exp_q.push_back(e);
                end
            end
        end
        in_valid = 1'b1;
    endtask

    task automatic drain_wait();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
    endtask

    // Transfer happens at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got data=%h row=%0d col=%0d, nothing expected",
                         out_data, out_row, out_col);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_data, out_row, out_col, out_last} !== mon_e) begin
                    errors++;
                    $display("FAIL stream_elem: got data=%h row=%0d col=%0d last=%0d, expected data=%h row=%0d col=%0d last=%0d",
                             out_data, out_row, out_col, out_last,
                             mon_e.data, mon_e.row, mon_e.col, mon_e.last);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, out_data, out_row, out_col, out_last, overflow, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got valid=%0d data=%h row=%0d col=%0d last=%0d ovf=%0d in_ready=%0d, expected 0 0000 0 0 0 0 1",
                     out_valid, out_data, out_row, out_col, out_last, overflow, in_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        present(0, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 16'h0100}) begin
            errors++;
            $display("FAIL single_latency: got valid=%0d data=%h, expected 1 0100", out_valid, out_data);
        end
        tick();
        checks++;
`ifdef MATRIX_SERIALIZER_PEND_EN
        if (in_ready !== 1'b1) begin
`else
        if (in_ready !== 1'b0) begin
`endif
            errors++;
            $display("FAIL single_in_ready_mid: got %0d", in_ready);
        end
        tick();
        tick();
        checks++;
        if ({out_last, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL single_last: got last=%0d in_ready=%0d, expected 1 1", out_last, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_end: got valid=%0d pending=%0d, expected 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        present(1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, out_data, out_row, out_col} !== {1'b1, 16'h1101, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%0d data=%h row=%0d col=%0d, expected 1 1101 0 1",
                         i, out_valid, out_data, out_row, out_col);
            end
            tick();
        end
        out_ready = 1'b1;
        drain_wait();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got pending=%0d valid=%0d, expected 0 0", exp_q.size(), out_valid);
        end
    endtask

`ifndef MATRIX_SERIALIZER_PEND_EN
    task automatic test_drop();
        out_ready = 1'b1;
        present(2, 1'b1);
        tick();
        out_ready = 1'b0;
        present(3, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({overflow, out_data, out_row, out_col} !== {1'b1, 16'h2100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drop_overflow: got ovf=%0d data=%h row=%0d col=%0d, expected 1 2100 0 0",
                     overflow, out_data, out_row, out_col);
        end
        out_ready = 1'b1;
        drain_wait();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_drain: got pending=%0d valid=%0d ovf=%0d, expected 0 0 1",
                     exp_q.size(), out_valid, overflow);
        end
    endtask
`endif

    task automatic test_back_to_back();
        out_ready = 1'b1;
        present(4, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({out_last, in_ready, out_data} !== {1'b1, 1'b1, 16'h4201}) begin
            errors++;
            $display("FAIL b2b_final: got last=%0d in_ready=%0d data=%h, expected 1 1 4201",
                     out_last, in_ready, out_data);
        end
        present(5, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, out_row, out_col} !== {1'b1, 16'h5100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_no_bubble: got valid=%0d data=%h row=%0d col=%0d, expected 1 5100 0 0",
                     out_valid, out_data, out_row, out_col);
        end
        drain_wait();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got pending=%0d valid=%0d, expected 0 0", exp_q.size(), out_valid);
        end
    endtask

`ifdef MATRIX_SERIALIZER_PEND_EN
    task automatic test_pend();
        out_ready = 1'b1;
        present(6, 1'b1);
        tick();
        present(7, 1'b1);
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL pend_capture: got ovf=%0d, expected 0", overflow);
        end
        present(8, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL pend_overflow: got ovf=%0d, expected 1", overflow);
        end
        for (int cyc = 3; cyc <= 8; cyc++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL pend_gapless[%0d]: got valid=%0d, expected 1", cyc, out_valid);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pend_end: got valid=%0d pending=%0d, expected 0 0", out_valid, exp_q.size());
        end
    endtask
`endif

    task automatic test_mid_reset();
        out_ready = 1'b1;
        present(9, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({out_valid, out_data, out_row, out_col, out_last, overflow, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_values: got valid=%0d data=%h row=%0d col=%0d last=%0d ovf=%0d in_ready=%0d, expected 0 0000 0 0 0 0 1",
                     out_valid, out_data, out_row, out_col, out_last, overflow, in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        present(10, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, out_row, out_col} !== {1'b1, 16'hA100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_restart: got valid=%0d data=%h row=%0d col=%0d, expected 1 a100 0 0",
                     out_valid, out_data, out_row, out_col);
        end
        drain_wait();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drain: got pending=%0d valid=%0d, expected 0 0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) m_in[r][c] = '0;
        end
        test_reset();
        test_single();
        test_backpressure();
`ifndef MATRIX_SERIALIZER_PEND_EN
        test_drop();
`endif
        test_back_to_back();
`ifdef MATRIX_SERIALIZER_PEND_EN
        test_pend();
`endif
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
